pll_cfg_seq: RTL

Configuration and power-sequencing stage for the PLL600V3 macro. It holds the 16-bit PLL configuration word written by the system register bus and drives the PLL control pins. It sequences every reconfiguration as follows: assert power-down, apply the new word, release power-down, then wait for lock. Synchronised lock status, loss-of-lock and timeout flags are reported back to software.

---
 rtl/pll_cfg_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pll_cfg_seq.sv
// Configuration and power-down sequencer for the PLL600V3 macro.
// Optional lock timeout and error state: define PLL_CFG_TIMEOUT_EN.
module pll_cfg_seq #(
  parameter int unsigned PD_CYC  = 16,
  parameter int unsigned LOCK_TO = 1024,
  parameter logic [15:0] CFG_RST = 16'h0000
) (
  input  logic        BMCLK1X,
  input  logic        RSTB,
  input  logic        WE,
  input  logic [15:0] WDATA,
  input  logic        STCLR,
  input  logic        LKDET,
  output logic        PD,
  output logic        SYNCEN,
  output logic        SG1,
  output logic        TM2,
  output logic        TM1,
  output logic [4:0]  CHP,
  output logic [1:0]  VCOD,
  output logic [4:0]  DIV,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        LOCKED,
  output logic        LOST,
  output logic        LOCK_ERR
);

  localparam logic [1:0] S_PD   = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [15:0] PD_LAST = 16'(PD_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(LOCK_TO - 1);

  logic [15:0] shadow_reg;
  logic [15:0] active_reg;
  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        lk_meta_reg;
  logic        lk_s_reg;
  logic        we_reg;
  logic        pd_reg;
  logic        busy_reg;
  logic        locked_reg;
  logic        lost_reg;
  logic        lost_set;
`ifdef PLL_CFG_TIMEOUT_EN
  logic        lock_err_reg;
  logic        to_set;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lost_set   = 1'b0;
`ifdef PLL_CFG_TIMEOUT_EN
    to_set     = 1'b0;
`endif
    case (state_reg)
      S_PD: begin
        cnt_next = cnt_reg + 16'd1;
        if (cnt_reg == PD_LAST) begin
          state_next = S_WAIT;
          cnt_next   = 16'd0;
        end
      end
      S_WAIT: begin
`ifdef PLL_CFG_TIMEOUT_EN
        cnt_next = cnt_reg + 16'd1;
        if (lk_s_reg) begin
          state_next = S_LOCK;
        end else if (cnt_reg == TO_LAST) begin
          state_next = S_ERR;
          to_set     = 1'b1;
        end
`else
        // Without the timeout the counter only saturates; it never ends the wait.
        if (cnt_reg != TO_LAST) cnt_next = cnt_reg + 16'd1;
        if (lk_s_reg) state_next = S_LOCK;
`endif
      end
      S_LOCK: begin
        if (!lk_s_reg) begin
          state_next = S_WAIT;
          cnt_next   = 16'd0;
          lost_set   = 1'b1;
        end
      end
      default: begin
      end
    endcase
    // A write restarts the sequence and overrides any other transition.
    if (we_reg) begin
      state_next = S_PD;
      cnt_next   = 16'd0;
      lost_set   = 1'b0;
`ifdef PLL_CFG_TIMEOUT_EN
      to_set     = 1'b0;
`endif
    end
  end

  always_ff @(posedge BMCLK1X or negedge RSTB) begin
    if (!RSTB) begin
      shadow_reg   <= CFG_RST;
      active_reg   <= CFG_RST;
      cnt_reg      <= 16'd0;
      state_reg    <= S_PD;
      lk_meta_reg  <= 1'b0;
      lk_s_reg     <= 1'b0;
      we_reg       <= 1'b0;
      pd_reg       <= 1'b1;
      busy_reg     <= 1'b1;
      locked_reg   <= 1'b0;
      lost_reg     <= 1'b0;
`ifdef PLL_CFG_TIMEOUT_EN
      lock_err_reg <= 1'b0;
`endif
    end else begin
      lk_meta_reg <= LKDET;
      lk_s_reg    <= lk_meta_reg;
      we_reg      <= WE;
      if (WE) shadow_reg <= WDATA;
      // The new word reaches the pins only in the first power-down cycle.
      if (state_reg == S_PD && cnt_reg == 16'd0) active_reg <= shadow_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pd_reg     <= (state_next == S_PD) || (state_next == S_ERR);
      busy_reg   <= (state_next == S_PD) || (state_next == S_WAIT);
      locked_reg <= (state_next == S_LOCK);
      if (lost_set) lost_reg <= 1'b1;
      else if (STCLR) lost_reg <= 1'b0;
`ifdef PLL_CFG_TIMEOUT_EN
      if (to_set) lock_err_reg <= 1'b1;
      else if (STCLR) lock_err_reg <= 1'b0;
`endif
    end
  end

  assign PD     = pd_reg;
  assign BUSY   = busy_reg;
  assign LOCKED = locked_reg;
  assign LOST   = lost_reg;
  assign RDATA  = active_reg;
  assign SYNCEN = active_reg[15];
  assign SG1    = active_reg[14];
  assign TM2    = active_reg[13];
  assign TM1    = active_reg[12];
  assign CHP    = active_reg[11:7];
  assign VCOD   = active_reg[6:5];
  assign DIV    = active_reg[4:0];
`ifdef PLL_CFG_TIMEOUT_EN
  assign LOCK_ERR = lock_err_reg;
`else
  assign LOCK_ERR = 1'b0;
`endif

endmodule
